// File: rtl/input_debounce_pkg.sv
// Shared definitions for the input_debounce block: FSM state encoding and
// the legal range of the synchronizer depth.
package input_debounce_pkg;

  // Accepted-level / pending-change states. The encoding is fixed so that
  // firmware-visible debug taps and other blocks can decode it directly.
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } db_state_e;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/sync_ff.sv
// Generic flop-chain synchronizer for a single asynchronous input.
// Depth and reset level are parameters so the same block can sit in front
// of a button (idles low) or a UART receive line (idles high).
module sync_ff #(
  parameter int   DEPTH     = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain;

  // Shift the raw input through DEPTH flops; bit 0 is the metastable stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chain <= {DEPTH{RESET_VAL}};
    end else begin
      chain <= {chain[DEPTH-2:0], d};
    end
  end

  assign q = chain[DEPTH-1];

endmodule

// File: rtl/input_debounce.sv
// Debouncer for a raw board input (button or switch).
//
// The input is synchronized, then a four-state FSM accepts a level change
// only after the new level has been seen on DEBOUNCE_CYCLES consecutive
// cycles. Edge pulses accompany each accepted change. Any sample of the old
// level while a change is pending aborts it, so bounce trains whose phases
// are all shorter than DEBOUNCE_CYCLES never reach the outputs.
//
// Optional feature: define DEBOUNCE_LONG_PRESS_EN to build the long-press
// detector (hold_long). Without it hold_long is a constant 0.
module input_debounce
  import input_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LONG_CYCLES     = 100000000,
  parameter int CNT_W           = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic btn_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic hold_long
);

  // Largest value either counter can hold.
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  // Elaboration-time guards on the configuration.
  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync_stages
    $error("input_debounce: SYNC_STAGES must be in 2..4");
  end
  if (DEBOUNCE_CYCLES < 2 || longint'(DEBOUNCE_CYCLES) > CNT_MAX) begin : g_bad_debounce
    $error("input_debounce: DEBOUNCE_CYCLES must be in 2..2**CNT_W-1");
  end
  if (LONG_CYCLES < 2 || longint'(LONG_CYCLES) > CNT_MAX) begin : g_bad_long
    $error("input_debounce: LONG_CYCLES must be in 2..2**CNT_W-1");
  end

  // The sample that moves the FSM from STABLE_x into WAIT_y is the first
  // stable cycle of the new level; the WAIT state then needs
  // DEBOUNCE_CYCLES-1 more. With cnt cleared on entry, the final sample
  // is the one that finds cnt at DEBOUNCE_CYCLES-2, so the accepted level
  // lands SYNC_STAGES+DEBOUNCE_CYCLES edges after the input first changes.
  localparam logic [CNT_W-1:0] ACCEPT_AT = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic             btn_s;
  db_state_e        state_q;
  db_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_d;
  logic             rise_d;
  logic             fall_d;

  sync_ff #(
    .DEPTH     (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (btn_in),
    .q       (btn_s)
  );

  // State, debounce counter and registered outputs; reset wins over all.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= STABLE_LO;
      cnt_q      <= '0;
      btn_out    <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      btn_out    <= level_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
    end
  end

  // Next-state, counter and output decode. cnt only counts in WAIT states
  // and is bounded by ACCEPT_AT, so it can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = btn_out;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (btn_s) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!btn_s) begin
          // Glitch: drop the pending rise, outputs untouched.
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == ACCEPT_AT) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!btn_s) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (btn_s) begin
          // Glitch: drop the pending fall, outputs untouched.
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == ACCEPT_AT) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic [CNT_W-1:0] long_cnt;
  logic             stay_hi;

  // Only cycles where the FSM both was and remains in STABLE_HI count, so
  // long_cnt is 0 on the accept edge and is cleared on the leaving edge.
  assign stay_hi = (state_q == STABLE_HI) && (state_d == STABLE_HI);

  // Long-press counter (saturating) and its single registered pulse. The
  // pulse is raised the cycle after long_cnt reaches LONG_CYCLES-1, i.e.
  // LONG_CYCLES cycles after rise_pulse; saturation prevents a repeat.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      long_cnt  <= '0;
      hold_long <= 1'b0;
    end else begin
      hold_long <= (state_q == STABLE_HI) && (long_cnt == LONG_LAST);
      if (!stay_hi) begin
        long_cnt <= '0;
      end else if (long_cnt != LONG_MAX) begin
        long_cnt <= long_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign hold_long = 1'b0;
`endif

endmodule
